// File: rtl/mem_ops_pkg.sv
// Shared definitions for the multiple-register load/store path.
// Holds the opcode patterns for LDM/STM/PUSH/POP, the sequencer state
// encoding, the architectural indices of SP/LR/PC, and small decode helpers.
package mem_ops_pkg;

    localparam logic [3:0] REG_SP = 4'd13;
    localparam logic [3:0] REG_LR = 4'd14;
    localparam logic [3:0] REG_PC = 4'd15;

    // Instruction bits 15:11 identify STM/LDM; bits 10:9 belong to Rn.
    localparam logic [4:0] STM_PREFIX  = 5'b11000;
    localparam logic [4:0] LDM_PREFIX  = 5'b11001;
    localparam logic [6:0] PUSH_OPCODE = 7'b1011010;
    localparam logic [6:0] POP_OPCODE  = 7'b1011110;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_DRAIN,
        ST_DONE
    } state_t;

    typedef enum logic [2:0] {
        OP_NONE,
        OP_STM,
        OP_LDM,
        OP_PUSH,
        OP_POP
    } op_kind_t;

    function automatic op_kind_t decode_op(input logic [6:0] op);
        op_kind_t kind;
        kind = OP_NONE;
        if (op[6:2] == STM_PREFIX)
            kind = OP_STM;
        else if (op[6:2] == LDM_PREFIX)
            kind = OP_LDM;
        else if (op == PUSH_OPCODE)
            kind = OP_PUSH;
        else if (op == POP_OPCODE)
            kind = OP_POP;
        return kind;
    endfunction

    function automatic logic [3:0] popcount9(input logic [8:0] m);
        logic [3:0] cnt;
        cnt = 4'd0;
        for (int i = 0; i < 9; i++)
            cnt = cnt + {3'd0, m[i]};
        return cnt;
    endfunction

endpackage

// File: rtl/lowest_set_bit.sv
// Priority encoder returning the index of the lowest set bit of a 9-bit
// pending-register mask. Bits 0..7 map to R0..R7, bit 8 to the LR/PC slot,
// so LR/PC is naturally served last.
// Ports:
//   mask  - pending register mask
//   index - index (0..8) of the lowest set bit; 0 when mask is empty
module lowest_set_bit (
    input  logic [8:0] mask,
    output logic [3:0] index
);

    always_comb begin
        index = 4'd0;
        // Scan downward so the lowest set bit is the last one to win.
        for (int i = 8; i >= 0; i--) begin
            if (mask[i])
                index = 4'(i);
        end
    end

endmodule

// File: rtl/multi_reg_sequencer.sv
// Sequencer for LDM/STM/PUSH/POP: breaks one multiple-register instruction
// into one memory access per cycle, ascending register order, LR/PC last.
// Ports:
//   clk, rst                  - clock, synchronous active-high reset
//   start, opcode, rn,        - request and instruction fields, sampled
//   reg_list, extra_bit,        only when start is accepted in IDLE
//   base_val
//   stall                     - downstream hold; freezes the access stream
//   reg_raddr / reg_rdata     - combinational register-file read for stores
//   mem_write_en, mem_opcode,
//   mem_addr, mem_data_out    - data-memory stage request
//   mem_rdata                 - data-memory read data (one-cycle latency)
//   wb_en, wb_reg, wb_data    - load writeback
//   base_wb_en/_reg/_val      - base register / SP update, pulsed with done
//   busy, done                - status
module multi_reg_sequencer
    import mem_ops_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [6:0]  opcode,
    input  logic [2:0]  rn,
    input  logic [7:0]  reg_list,
    input  logic        extra_bit,
    input  logic [31:0] base_val,
    input  logic        stall,
    output logic [3:0]  reg_raddr,
    input  logic [31:0] reg_rdata,
    output logic        mem_write_en,
    output logic [6:0]  mem_opcode,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_data_out,
    input  logic [31:0] mem_rdata,
    output logic        wb_en,
    output logic [3:0]  wb_reg,
    output logic [31:0] wb_data,
    output logic        base_wb_en,
    output logic [3:0]  base_wb_reg,
    output logic [31:0] base_wb_val,
    output logic        busy,
    output logic        done
);

    state_t      state_reg;
    op_kind_t    op_reg;
    logic [6:0]  opcode_reg;
    logic [8:0]  mask_reg;
    logic [31:0] addr_reg;
    logic [3:0]  extra_idx_reg;
    logic        base_ok_reg;
    logic [3:0]  base_idx_reg;
    logic [31:0] base_upd_reg;
    logic        wb_en_reg;
    logic [3:0]  wb_reg_reg;

    // Decode of the incoming request. Unrecognised opcodes get an empty
    // mask and therefore complete immediately with no access.
    op_kind_t    start_op;
    logic        start_stack;
    logic [8:0]  start_mask;
    logic [3:0]  start_n;
    logic [31:0] span;

    assign start_op    = decode_op(opcode);
    assign start_stack = (start_op == OP_PUSH) || (start_op == OP_POP);
    assign start_mask  = (start_op == OP_NONE) ? 9'd0
                                               : {extra_bit & start_stack, reg_list};
    assign start_n     = popcount9(start_mask);
    assign span        = {26'd0, start_n, 2'b00};

    // Current access.
    logic [3:0] lsb_idx;
    logic [3:0] cur_reg;
    logic [8:0] mask_after;
    logic       is_store;
    logic       issue;

    lowest_set_bit u_lowest_set_bit (
        .mask  (mask_reg),
        .index (lsb_idx)
    );

    assign cur_reg    = (lsb_idx == 4'd8) ? extra_idx_reg : lsb_idx;
    assign mask_after = mask_reg & (mask_reg - 9'd1);
    assign is_store   = (op_reg == OP_STM) || (op_reg == OP_PUSH);
    // Reset suppresses the access of the reset cycle itself.
    assign issue      = (state_reg == ST_ACCESS) && !stall && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            op_reg        <= OP_NONE;
            opcode_reg    <= 7'd0;
            mask_reg      <= 9'd0;
            addr_reg      <= 32'd0;
            extra_idx_reg <= 4'd0;
            base_ok_reg   <= 1'b0;
            base_idx_reg  <= 4'd0;
            base_upd_reg  <= 32'd0;
            wb_en_reg     <= 1'b0;
            wb_reg_reg    <= 4'd0;
        end else begin
            // Load data returns one cycle after the read is issued.
            wb_en_reg <= issue && !is_store;
            if (issue && !is_store)
                wb_reg_reg <= cur_reg;

            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        op_reg        <= start_op;
                        opcode_reg    <= opcode;
                        mask_reg      <= start_mask;
                        addr_reg      <= (start_op == OP_PUSH) ? base_val - span : base_val;
                        extra_idx_reg <= (start_op == OP_PUSH) ? REG_LR : REG_PC;
                        base_idx_reg  <= start_stack ? REG_SP : {1'b0, rn};
                        base_upd_reg  <= (start_op == OP_PUSH) ? base_val - span
                                                               : base_val + span;
                        // An LDM that reloads its own base keeps the loaded value.
                        base_ok_reg   <= (start_n != 4'd0) &&
                                         !((start_op == OP_LDM) && reg_list[rn]);
                        state_reg     <= (start_n == 4'd0) ? ST_DONE : ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (!stall) begin
                        mask_reg <= mask_after;
                        addr_reg <= addr_reg + 32'd4;
                        if (mask_after == 9'd0)
                            state_reg <= is_store ? ST_DONE : ST_DRAIN;
                    end
                end
                ST_DRAIN: state_reg <= ST_DONE;
                default:  state_reg <= ST_IDLE;
            endcase
        end
    end

    assign busy         = (state_reg != ST_IDLE);
    assign done         = (state_reg == ST_DONE);
    assign mem_opcode   = opcode_reg;
    assign mem_addr     = addr_reg;
    assign mem_write_en = issue && is_store;
    assign reg_raddr    = (state_reg == ST_ACCESS) ? cur_reg : 4'd0;
    assign mem_data_out = mem_write_en ? reg_rdata : 32'd0;
    assign wb_en        = wb_en_reg && !rst;
    assign wb_reg       = wb_reg_reg;
    assign wb_data      = mem_rdata;
    assign base_wb_en   = done && base_ok_reg;
    assign base_wb_reg  = base_idx_reg;
    assign base_wb_val  = base_upd_reg;

endmodule

// File: doc/multi_reg_sequencer.md
MULTI_REG_SEQUENCER -- requirements
Module: multi_reg_sequencer

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state changes on its rising edge.
REQ-002 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-003 SHALL have port start, input, 1, one-cycle request to begin a multiple-register operation.
REQ-004 SHALL have port opcode, input, 7, instruction bits 15:9: STORE_MULTIPLE 1100_0??, LOAD_MULTIPLE 1100_1??, PUSH 1011_010, POP 1011_110.
REQ-005 SHALL have port rn, input, 3, base register for LDM/STM; ignored for PUSH/POP.
REQ-006 SHALL have port reg_list, input, 8, R0-R7 select bits.
REQ-007 SHALL have port extra_bit, input, 1, instruction bit 8: LR for PUSH, PC for POP; ignored for LDM/STM.
REQ-008 SHALL have port base_val, input, 32, value of Rn or SP, sampled on accepted start.
REQ-009 SHALL have port stall, input, 1, downstream hold request.
REQ-010 SHALL have port reg_raddr/reg_rdata, output 4 / input 32, combinational register-file read for store data.
REQ-011 SHALL have mem_write_en (1), mem_opcode (7), mem_addr (32) and mem_data_out (32), all outputs, driving the data-memory stage inputs.
REQ-012 SHALL have wb_en (1), wb_reg (4) and wb_data (32), all outputs, for load writeback; wb_data passes through the data-memory read data input mem_rdata (32).
REQ-013 SHALL have base_wb_en (1), base_wb_reg (4) and base_wb_val (32), all outputs, for base/SP update.
REQ-014 SHALL have outputs busy (1) and done (1).

Function
REQ-015 SHALL accept start only in IDLE; start while busy SHALL be ignored.
REQ-016 SHALL count n = popcount(reg_list) + (extra_bit for PUSH/POP).
REQ-017 SHALL use states IDLE, ACCESS, DRAIN and DONE: IDLE->ACCESS on accepted start with n>0; IDLE->DONE on n=0; ACCESS->DRAIN after the last load issue; ACCESS->DONE after the last store issue; DRAIN->DONE after one cycle; DONE->IDLE after one cycle.
REQ-018 SHALL issue one access per non-stalled ACCESS cycle, in ascending register order, with LR or PC last.
REQ-019 SHALL use start address base_val for STM, LDM and POP, and base_val - 4*n for PUSH; each access SHALL add 4 (mod 2^32).
REQ-020 SHALL drive mem_opcode with the latched opcode throughout the operation.
REQ-021 On stores, SHALL set reg_raddr to the current register, mem_data_out to reg_rdata, and mem_write_en=1.
REQ-022 On loads, SHALL hold mem_write_en at 0; wb_en, wb_reg and wb_data SHALL assert exactly one cycle after the issuing cycle, matching the one-cycle read latency.
REQ-023 While stall=1, SHALL not advance address, register pointer or state, and SHALL hold mem_write_en at 0; a stalled cycle SHALL produce no wb_en.
REQ-024 SHALL set base_wb_val to base_val + 4*n for LDM, STM and POP, and base_val - 4*n for PUSH.
REQ-025 SHALL pulse base_wb_en with done, except for LDM with Rn in reg_list and for n=0.
REQ-026 SHALL set base_wb_reg to Rn for LDM/STM and 13 for PUSH/POP.
REQ-027 SHALL assert busy in every state except IDLE, and SHALL pulse done for one cycle in DONE.

Reset
REQ-028 On rst, SHALL enter IDLE and clear busy, done, mem_write_en, wb_en, base_wb_en, mem_addr, mem_data_out, mem_opcode, wb_reg and reg_raddr to 0.
REQ-029 Reset mid-operation SHALL abort with no further write or writeback, including any pending load writeback.

Structure
REQ-030 SHALL take the opcode patterns, state enum and register constants SP=13, LR=14 and PC=15 from shared package mem_ops_pkg.
REQ-031 SHALL instantiate one sub-module, lowest_set_bit, which returns the index of the next pending register from a 9-bit mask.

Verification
REQ-032 STM rn=2, list=0x0B, base=0x100 -> writes R0@0x100, R1@0x104, R3@0x108; base_wb R2=0x10C.
REQ-033 PUSH list=0x11, extra=1, SP=0x200 -> writes R0@0x1F4, R4@0x1F8, LR@0x1FC; base_wb R13=0x1F4.
REQ-034 POP list=0x02, extra=1, SP=0x1F8 -> wb R1 then R15, each one cycle after its read issue; base_wb R13=0x200.
REQ-035 LDM rn=1, list=0x06 -> loads R1 and R2; base_wb_en never asserted.
REQ-036 STM with stall asserted for 2 cycles mid-list -> no duplicate or skipped write; done is delayed by 2 cycles.
REQ-037 Empty list -> done the next cycle with no access; rst during PUSH -> idle, no writes after the reset cycle.
